// File: rtl/fifo_sync_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_stream_if
// Brief    : Ready/valid stream bundle for both sides of fifo_sync_stream.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_sync_stream_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // master: producer/consumer environment; slave: the FIFO itself
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_stream (with memory_dp storage)
// Brief    : Single-clock FWFT stream FIFO: RAM plus a 2-entry skid stage.
// Revision : 1.0 - initial release
// ============================================================================
module memory_dp #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  wire logic          wr_clk,
    input  wire logic          wr_en,
    input  wire logic [DW-1:0] wr_wem,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [DW-1:0] wr_din,
    input  wire logic          rd_clk,
    input  wire logic          rd_en,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [DW-1:0] rd_dout
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= (r_mem[wr_addr] & ~wr_wem) | (wr_din & wr_wem);
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_en) begin
            rd_dout <= r_mem[rd_addr];
        end
    end
endmodule

module fifo_sync_stream #(
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int PROG_FULL = DEPTH - 2,
    parameter int AW        = $clog2(DEPTH),
    parameter int CW        = $clog2(DEPTH + 2) + 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fifo_sync_stream_if.slave  bus,
    output logic      [CW-1:0] count,
    output logic               prog_full
);
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          r_rd_inflight;
    logic [1:0]    r_skid_cnt;
    logic [DW-1:0] r_skid_head;
    logic [DW-1:0] r_skid_tail;
    logic [CW-1:0] r_count;
    logic          r_prog_full;

    logic [AW:0]   w_mem_cnt;
    logic          w_mem_full;
    logic          w_mem_empty;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_issue;
    logic [DW-1:0] w_rd_dout;
    logic [CW-1:0] w_count_next;

    assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_mem_full  = (w_mem_cnt == C_DEPTH);
    assign w_mem_empty = (w_mem_cnt == '0);

    assign bus.in_ready  = !w_mem_full;
    assign bus.out_valid = (r_skid_cnt != 2'd0);
    assign bus.out_data  = r_skid_head;

    assign w_push = bus.in_valid & !w_mem_full;
    assign w_pop  = (r_skid_cnt != 2'd0) & bus.out_ready;

    // Skid slots already claimed after this cycle's pop; prefetch only into free room
    assign w_occ   = {1'b0, r_skid_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
    assign w_issue = !w_mem_empty && (w_occ < 3'd2);

    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    memory_dp #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .wr_clk  (clk),
        .wr_en   (w_push),
        .wr_wem  ({DW{1'b1}}),
        .wr_addr (r_wr_ptr[AW-1:0]),
        .wr_din  (bus.in_data),
        .rd_clk  (clk),
        .rd_en   (w_issue),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .rd_dout (w_rd_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_rd_inflight <= 1'b0;
            r_skid_cnt    <= 2'd0;
            r_count       <= '0;
            r_prog_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_rd_inflight <= w_issue;
            r_skid_cnt    <= r_skid_cnt + {1'b0, r_rd_inflight} - {1'b0, w_pop};
            r_count       <= w_count_next;
            r_prog_full   <= (w_count_next >= CW'(PROG_FULL));
        end
    end

    // Data slots carry no reset: contents are meaningless while r_skid_cnt says empty
    always_ff @(posedge clk) begin
        if (r_rd_inflight) begin
            if (w_pop) begin
                if (r_skid_cnt == 2'd2) begin
                    r_skid_head <= r_skid_tail;
                    r_skid_tail <= w_rd_dout;
                end else begin
                    r_skid_head <= w_rd_dout;
                end
            end else if (r_skid_cnt == 2'd0) begin
                r_skid_head <= w_rd_dout;
            end else begin
                r_skid_tail <= w_rd_dout;
            end
        end else if (w_pop) begin
            r_skid_head <= r_skid_tail;
        end
    end

    assign count     = r_count;
    assign prog_full = r_prog_full;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_stream
// Brief    : Self-checking bench: directed vector table, hand sequences, random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_stream;
    localparam int DW = 8;
    localparam int CW = 4;

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_data;
        int            e_cnt;
        logic          e_ir;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [CW-1:0] count;
    logic          prog_full;
    int            n_checks;
    int            n_err;

    fifo_sync_stream_if #(.DW(DW)) bus ();

    fifo_sync_stream #(
        .DW        (DW),
        .DEPTH     (4),
        .PROG_FULL (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .count     (count),
        .prog_full (prog_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] din, input logic ordy,
                                input logic e_ov, input logic [DW-1:0] e_data,
                                input int e_cnt, input logic e_ir);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy;
        v.e_ov = e_ov; v.e_data = e_data; v.e_cnt = e_cnt; v.e_ir = e_ir;
        return v;
    endfunction

    vec_t       vecs [19];
    logic [7:0] exp_q [$];

    initial begin
        int sent, got, stall, pushed, popped, cycles;
        logic s_ir, s_ov;
        n_checks = 0;
        n_err    = 0;

        // Each row: inputs for this cycle, and outputs expected before its edge
        vecs[0]  = mk(1, 8'hA1, 0, 0, 8'h00, 0, 1);
        vecs[1]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 1);
        vecs[2]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 1);
        vecs[3]  = mk(0, 8'h00, 1, 1, 8'hA1, 1, 1);
        vecs[4]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1);
        vecs[5]  = mk(1, 8'h01, 0, 0, 8'h00, 0, 1);
        vecs[6]  = mk(1, 8'h02, 0, 0, 8'h00, 1, 1);
        vecs[7]  = mk(1, 8'h03, 0, 0, 8'h00, 2, 1);
        vecs[8]  = mk(1, 8'h04, 0, 1, 8'h01, 3, 1);
        vecs[9]  = mk(1, 8'h05, 0, 1, 8'h01, 4, 1);
        vecs[10] = mk(1, 8'h06, 0, 1, 8'h01, 5, 1);
        vecs[11] = mk(0, 8'h00, 0, 1, 8'h01, 6, 0);
        vecs[12] = mk(0, 8'h00, 1, 1, 8'h01, 6, 0);
        vecs[13] = mk(0, 8'h00, 1, 1, 8'h02, 5, 1);
        vecs[14] = mk(0, 8'h00, 1, 1, 8'h03, 4, 1);
        vecs[15] = mk(0, 8'h00, 1, 1, 8'h04, 3, 1);
        vecs[16] = mk(0, 8'h00, 1, 1, 8'h05, 2, 1);
        vecs[17] = mk(0, 8'h00, 1, 1, 8'h06, 1, 1);
        vecs[18] = mk(0, 8'h00, 0, 0, 8'h00, 0, 1);

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_out_valid", 32'(bus.out_valid), 0);
        chk("reset_in_ready", 32'(bus.in_ready), 1);
        chk("reset_prog_full", 32'(prog_full), 0);

        // Directed table: single word, fill to capacity, drain
        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].din;
            bus.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_prog_full", i), 32'(prog_full), 32'(vecs[i].e_cnt >= 2));
        end

        // Streaming: first word appears two edges after acceptance, so three
        // words are held once output starts, and that holds while both sides run
        sent = 0;
        got  = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            bus.in_valid  = (sent < 20);
            bus.in_data   = 8'(sent + 1);
            bus.out_ready = 1'b1;
            #1;
            if (got > 0 && got < 20) chk("stream_no_gap", 32'(bus.out_valid), 1);
            if (t >= 3 && t <= 20) chk("stream_count", 32'(count), 3);
            if (bus.out_valid) begin
                chk("stream_data", 32'(bus.out_data), 32'(got + 1));
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        chk("stream_words_out", 32'(got), 20);
        chk("stream_end_count", 32'(count), 0);

        // Random traffic against a queue model
        pushed = 0;
        popped = 0;
        stall  = 0;
        cycles = 0;
        exp_q.delete();
        while ((popped < 1000) && (cycles < 20000)) begin
            @(negedge clk);
            cycles++;
            bus.in_valid  = (pushed < 1000) && ($urandom_range(1, 0) == 1);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(1, 0) == 1);
            #1;
            chk("rnd_count", 32'(count), 32'(exp_q.size()));
            chk("rnd_prog_full", 32'(prog_full), 32'(exp_q.size() >= 2));
            if (exp_q.size() == 0) chk("rnd_empty_out_valid", 32'(bus.out_valid), 0);
            if (exp_q.size() < 4)  chk("rnd_in_ready_room", 32'(bus.in_ready), 1);
            if (exp_q.size() == 6) chk("rnd_in_ready_full", 32'(bus.in_ready), 0);
            if (bus.out_valid && exp_q.size() > 0)
                chk("rnd_out_data", 32'(bus.out_data), 32'(exp_q[0]));
            stall = (exp_q.size() > 0 && !bus.out_valid) ? stall + 1 : 0;
            if (stall > 0) chk("rnd_head_latency", 32'(stall <= 2), 1);
            s_ir = bus.in_ready;
            s_ov = bus.out_valid;
            if (s_ov && bus.out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                popped++;
            end
            if (bus.in_valid && s_ir) begin
                exp_q.push_back(bus.in_data);
                pushed++;
            end
        end
        chk("rnd_completed", 32'(popped), 1000);

        // Reset while holding five words
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h30 + i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("pre_reset_count", 32'(count), 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_count", 32'(count), 0);
        chk("post_reset_out_valid", 32'(bus.out_valid), 0);
        chk("post_reset_in_ready", 32'(bus.in_ready), 1);
        chk("post_reset_prog_full", 32'(prog_full), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        cycles = 0;
        while (!bus.out_valid && cycles < 10) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("post_reset_valid_seen", 32'(bus.out_valid), 1);
        chk("post_reset_data", 32'(bus.out_data), 32'h77);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_reset_no_stale", 32'(bus.out_valid), 0);
        end
        chk("post_reset_final_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
